// File: rtl/ext_irq_ctrl_pkg.sv
// Shared register offsets and FSM state encoding for the external interrupt controller.
package ext_irq_ctrl_pkg;

    localparam logic [4:0] EIC_ENABLE   = 5'h00;
    localparam logic [4:0] EIC_EDGE     = 5'h04;
    localparam logic [4:0] EIC_PENDING  = 5'h08;
    localparam logic [4:0] EIC_PRIO     = 5'h0C;
    localparam logic [4:0] EIC_CLAIM    = 5'h10;
    localparam logic [4:0] EIC_COMPLETE = 5'h14;

    localparam logic [31:0] MCAUSE_INTP_EX = 32'h8000_000B;

    typedef enum logic [1:0] {
        EIC_IDLE = 2'd0,
        EIC_REQ  = 2'd1,
        EIC_SERV = 2'd2
    } eic_state_e;

endpackage

// File: rtl/ext_irq_ctrl_irq_sync_edge.sv
// Two-flop synchronizer for one asynchronous interrupt line, with rising-edge detect
// taken between the synchronized level and its one-cycle-delayed copy.
module irq_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic level_o,
    output logic rise_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: merges NUM_SRC lines into one trap request with
// priority arbitration, claim on trap ready and software COMPLETE to end service.
//
// state | meaning
// IDLE  | nothing eligible, no request toward trap
// REQ   | ex_trap_valid_o high, irq_id_o tracks the current winner
// SERV  | winner claimed and latched in irq_id_o until a matching COMPLETE
module ext_irq_ctrl
    import ext_irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int PRIO_W  = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_SRC-1:0]             irq_src_i,
    input  logic                           cfg_we_i,
    input  logic                           cfg_re_i,
    input  logic [4:0]                     cfg_addr_i,
    input  logic [31:0]                    cfg_wdata_i,
    output logic [31:0]                    cfg_rdata_o,
    output logic                           ex_trap_valid_o,
    input  logic                           ex_trap_ready_i,
    output logic [$clog2(NUM_SRC+1)-1:0]   irq_id_o
);

    localparam int IDW = $clog2(NUM_SRC + 1);
    localparam int PW  = NUM_SRC * PRIO_W;

    logic [NUM_SRC-1:0] sync_lvl;
    logic [NUM_SRC-1:0] sync_rise;
    logic [NUM_SRC-1:0] enable_q;
    logic [NUM_SRC-1:0] edge_q;
    logic [NUM_SRC-1:0] pend_q;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] clr_mask;
    logic [PW-1:0]      prio_q;
    eic_state_e         state;

    logic [4:0]         addr_w;
    logic               unused_addr;
    logic               claim;
    logic               complete_hit;
    logic [IDW-1:0]     win_id;
    logic [PRIO_W-1:0]  win_prio;
    logic               any_elig;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_sync
        irq_sync_edge u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .async_i (irq_src_i[g]),
            .level_o (sync_lvl[g]),
            .rise_o  (sync_rise[g])
        );
    end

    assign addr_w      = {cfg_addr_i[4:2], 2'b00};
    assign unused_addr = ^cfg_addr_i[1:0];

    assign claim        = (state == EIC_REQ) && ex_trap_ready_i;
    assign complete_hit = (state == EIC_SERV) && cfg_we_i && (addr_w == EIC_COMPLETE) &&
                          (cfg_wdata_i == 32'(irq_id_o));

    // Edge sources: a new rise beats a same-cycle W1C or claim clear.
    always_comb begin
        clr_mask = '0;
        if (cfg_we_i && (addr_w == EIC_PENDING)) begin
            clr_mask = cfg_wdata_i[NUM_SRC-1:0];
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (claim && (irq_id_o == IDW'(i + 1))) begin
                clr_mask[i] = 1'b1;
            end
        end
        pend_nxt = (edge_q & (sync_rise | (pend_q & ~clr_mask))) | (~edge_q & sync_lvl);
    end

    // Arbitrate on next-cycle pending so the request rises with the pending bit itself.
    always_comb begin
        win_id   = '0;
        win_prio = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pend_nxt[i] && enable_q[i] && (prio_q[i*PRIO_W +: PRIO_W] > win_prio)) begin
                win_prio = prio_q[i*PRIO_W +: PRIO_W];
                win_id   = IDW'(i + 1);
            end
        end
        any_elig = (win_id != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_q <= '0;
            edge_q   <= '0;
            prio_q   <= '0;
            pend_q   <= '0;
        end else begin
            pend_q <= pend_nxt;
            if (cfg_we_i) begin
                case (addr_w)
                    EIC_ENABLE: enable_q <= cfg_wdata_i[NUM_SRC-1:0];
                    EIC_EDGE:   edge_q   <= cfg_wdata_i[NUM_SRC-1:0];
                    EIC_PRIO:   prio_q   <= cfg_wdata_i[PW-1:0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= EIC_IDLE;
            ex_trap_valid_o <= 1'b0;
            irq_id_o        <= '0;
        end else begin
            case (state)
                EIC_IDLE: begin
                    if (any_elig) begin
                        state           <= EIC_REQ;
                        ex_trap_valid_o <= 1'b1;
                        irq_id_o        <= win_id;
                    end
                end
                EIC_REQ: begin
                    if (ex_trap_ready_i) begin
                        state           <= EIC_SERV;
                        ex_trap_valid_o <= 1'b0;
                    end else if (!any_elig) begin
                        state           <= EIC_IDLE;
                        ex_trap_valid_o <= 1'b0;
                        irq_id_o        <= '0;
                    end else begin
                        irq_id_o        <= win_id;
                    end
                end
                EIC_SERV: begin
                    if (complete_hit) begin
                        state    <= EIC_IDLE;
                        irq_id_o <= '0;
                    end
                end
                default: begin
                    state           <= EIC_IDLE;
                    ex_trap_valid_o <= 1'b0;
                    irq_id_o        <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rdata_o <= '0;
        end else if (cfg_re_i) begin
            case (addr_w)
                EIC_ENABLE:  cfg_rdata_o <= 32'(enable_q);
                EIC_EDGE:    cfg_rdata_o <= 32'(edge_q);
                EIC_PENDING: cfg_rdata_o <= 32'(pend_q);
                EIC_PRIO:    cfg_rdata_o <= 32'(prio_q);
                EIC_CLAIM:   cfg_rdata_o <= (state == EIC_SERV) ? 32'(irq_id_o) : 32'd0;
                default:     cfg_rdata_o <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Bench for ext_irq_ctrl: directed scenarios plus random traffic, all checked cycle by
// cycle against a behavioural model of pending/priority/claim rules.
module tb_ext_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  irq_src = '0;
    logic        cfg_we = 1'b0;
    logic        cfg_re = 1'b0;
    logic [4:0]  cfg_addr = '0;
    logic [31:0] cfg_wdata = '0;
    logic [31:0] cfg_rdata;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [3:0]  irq_id;

    int n_vec = 0;
    int n_err = 0;

    // model state
    bit [7:0]  m_en, m_edge, m_pend;
    bit [15:0] m_prio;
    int        m_state;   // 0 idle, 1 requesting, 2 in service
    int        m_id;
    bit        m_valid;
    bit [31:0] m_rdata;
    bit [7:0]  r1, r2, r3; // raw lines seen at the last three clock edges

    ext_irq_ctrl #(.NUM_SRC(8), .PRIO_W(2)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .irq_src_i       (irq_src),
        .cfg_we_i        (cfg_we),
        .cfg_re_i        (cfg_re),
        .cfg_addr_i      (cfg_addr),
        .cfg_wdata_i     (cfg_wdata),
        .cfg_rdata_o     (cfg_rdata),
        .ex_trap_valid_o (ex_valid),
        .ex_trap_ready_i (ex_ready),
        .irq_id_o        (irq_id)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_edge = 0; m_pend = 0; m_prio = 0;
        m_state = 0; m_id = 0; m_valid = 0; m_rdata = 0;
        r1 = 0; r2 = 0; r3 = 0;
    endtask

    task automatic model_step();
        bit [7:0] lvl, rise, clr, pn;
        bit [4:0] a;
        int best, bscore, p, s;
        if (!rst_n) begin
            model_reset();
            return;
        end
        a    = {cfg_addr[4:2], 2'b00};
        lvl  = r2;
        rise = r2 & ~r3;
        clr  = 0;
        if (cfg_we && a == 5'h08) clr = cfg_wdata[7:0];
        if (m_state == 1 && ex_ready) clr[m_id-1] = 1'b1;
        for (int i = 0; i < 8; i++)
            pn[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !clr[i])) : lvl[i];
        // highest priority wins, lower index breaks ties
        best = 0; bscore = -1;
        for (int i = 0; i < 8; i++) begin
            p = (m_prio >> (2 * i)) & 3;
            s = p * 8 + (7 - i);
            if (pn[i] && m_en[i] && p != 0 && s > bscore) begin
                bscore = s;
                best = i + 1;
            end
        end
        if (cfg_re) begin
            case (a)
                5'h00:   m_rdata = {24'b0, m_en};
                5'h04:   m_rdata = {24'b0, m_edge};
                5'h08:   m_rdata = {24'b0, m_pend};
                5'h0C:   m_rdata = {16'b0, m_prio};
                5'h10:   m_rdata = (m_state == 2) ? 32'(m_id) : 32'd0;
                default: m_rdata = 0;
            endcase
        end
        case (m_state)
            0: if (best != 0) begin m_state = 1; m_valid = 1; m_id = best; end
            1: begin
                if (ex_ready) begin m_state = 2; m_valid = 0; end
                else if (best == 0) begin m_state = 0; m_valid = 0; m_id = 0; end
                else m_id = best;
            end
            default: if (cfg_we && a == 5'h14 && cfg_wdata == 32'(m_id)) begin
                m_state = 0; m_id = 0;
            end
        endcase
        m_pend = pn;
        if (cfg_we) begin
            if (a == 5'h00) m_en = cfg_wdata[7:0];
            if (a == 5'h04) m_edge = cfg_wdata[7:0];
            if (a == 5'h0C) m_prio = cfg_wdata[15:0];
        end
        r3 = r2; r2 = r1; r1 = irq_src;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk("valid", ex_valid, m_valid);
        chk("irq_id", irq_id, m_id);
        chk("rdata", cfg_rdata, m_rdata);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a);
        cfg_re = 1'b1; cfg_addr = a;
        step();
        cfg_re = 1'b0;
    endtask

    task automatic pulse_ready();
        ex_ready = 1'b1;
        step();
        ex_ready = 1'b0;
    endtask

    initial begin
        model_reset();
        steps(3);
        chk("rst_valid", ex_valid, 0);
        chk("rst_id", irq_id, 0);
        chk("rst_rdata", cfg_rdata, 0);
        rst_n = 1'b1;
        step();

        // src3 edge, prio 2 -> id 4
        wr(5'h04, 32'h08);
        wr(5'h00, 32'h08);
        wr(5'h0C, 32'h80);
        irq_src[3] = 1'b1;
        steps(2);
        chk("src3_not_yet", ex_valid, 0);
        step();
        chk("src3_valid", ex_valid, 1);
        chk("src3_id", irq_id, 4);
        pulse_ready();
        chk("claim_valid_low", ex_valid, 0);
        rd(5'h10);
        chk("claim_rd", cfg_rdata, 4);
        rd(5'h08);
        chk("pend3_cleared", cfg_rdata & 32'h8, 0);

        // new edge during service, wrong and right COMPLETE
        irq_src[3] = 1'b0;
        steps(3);
        irq_src[3] = 1'b1;
        steps(3);
        rd(5'h08);
        chk("pend3_in_serv", cfg_rdata & 32'h8, 32'h8);
        wr(5'h14, 32'd2);
        rd(5'h10);
        chk("bad_complete", cfg_rdata, 4);
        wr(5'h14, 32'd4);
        chk("complete_idle", ex_valid, 0);
        step();
        chk("rereq_valid", ex_valid, 1);
        chk("rereq_id", irq_id, 4);

        // ready held for five cycles claims once
        ex_ready = 1'b1;
        steps(5);
        ex_ready = 1'b0;
        chk("held_ready_valid", ex_valid, 0);
        rd(5'h08);
        chk("held_ready_pend", cfg_rdata & 32'h8, 0);
        rd(5'h10);
        chk("held_ready_claim", cfg_rdata, 4);
        irq_src[3] = 1'b0;
        wr(5'h14, 32'd4);
        steps(4);
        chk("quiet_idle", ex_valid, 0);

        // tie between src1 and src5, then reprioritise
        wr(5'h04, 32'h2A);
        wr(5'h00, 32'h22);
        wr(5'h0C, 32'h0C0C);
        irq_src[1] = 1'b1; irq_src[5] = 1'b1;
        steps(3);
        chk("tie_id", irq_id, 2);
        wr(5'h0C, 32'h0C04);
        chk("reprio_pre", irq_id, 2);
        step();
        chk("reprio_id", irq_id, 6);
        pulse_ready();
        wr(5'h14, 32'd6);
        step();
        chk("src1_after", irq_id, 2);
        pulse_ready();
        wr(5'h14, 32'd2);
        irq_src[1] = 1'b0; irq_src[5] = 1'b0;
        steps(4);

        // level source src0 rises and falls before any claim
        wr(5'h00, 32'h01);
        wr(5'h0C, 32'h01);
        irq_src[0] = 1'b1;
        steps(3);
        chk("lvl_valid", ex_valid, 1);
        chk("lvl_id", irq_id, 1);
        irq_src[0] = 1'b0;
        steps(2);
        chk("lvl_still", ex_valid, 1);
        step();
        chk("lvl_drop", ex_valid, 0);
        chk("lvl_drop_id", irq_id, 0);

        // rise and W1C on src0 in the same cycle
        wr(5'h00, 32'h00);
        wr(5'h04, 32'h01);
        irq_src[0] = 1'b1;
        steps(2);
        wr(5'h08, 32'h01);
        rd(5'h08);
        chk("set_wins", cfg_rdata & 32'h1, 1);
        wr(5'h08, 32'h01);
        rd(5'h08);
        chk("w1c_clears", cfg_rdata & 32'h1, 0);

        // reset while in service
        wr(5'h04, 32'h00);
        wr(5'h00, 32'h01);
        step();
        chk("pre_rst_valid", ex_valid, 1);
        pulse_ready();
        rd(5'h10);
        chk("pre_rst_claim", cfg_rdata, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", ex_valid, 0);
        chk("async_id", irq_id, 0);
        chk("async_rdata", cfg_rdata, 0);
        model_reset();
        irq_src = '0;
        steps(2);
        rst_n = 1'b1;
        step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            cfg_we = ($urandom_range(0, 5) == 0);
            cfg_re = ($urandom_range(0, 3) == 0);
            cfg_addr = 5'($urandom_range(0, 31));
            cfg_wdata = $urandom;
            if (cfg_we && m_state == 2 && $urandom_range(0, 1) == 0) begin
                cfg_addr = 5'h14;
                cfg_wdata = 32'(m_id);
            end
            ex_ready = ($urandom_range(0, 2) == 0);
            step();
        end
        cfg_we = 1'b0; cfg_re = 1'b0; ex_ready = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
